// File: rtl/relu_maxpool_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : relu_maxpool_stage_pkg
// Description : Shared defaults and state encoding for the ReLU / 2x2
//               max-pool write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
package relu_maxpool_stage_pkg;

  // Default vector geometry: elements per vector and element width (INT8)
  localparam int c_length_default = 16;
  localparam int c_int8_width     = 8;

  // Default number of vectors making up one feature-map row
  localparam int c_pool_row_beats = 4;

  // Stage state: IDLE until the first beat of a frame, then either the
  // FILL/POOL row alternation or the pass-through bypass.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_POOL = 2'd2,
    ST_BYP  = 2'd3
  } state_t;

endpackage : relu_maxpool_stage_pkg
`default_nettype wire

// File: rtl/relu_maxpool_stage_lane.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_pair_lane
// Description : One pooled output element. Vertical max of current/previous
//               row for two neighbouring elements, horizontal max of the pair,
//               then optional ReLU. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_pair_lane #(
  parameter int DW = 8
) (
  input  logic [2*DW-1:0] cur_pair,
  input  logic [2*DW-1:0] prev_pair,
  input  logic            relu_en,
  output logic [DW-1:0]   pooled
);

  logic signed [DW-1:0] w_cur_lo;
  logic signed [DW-1:0] w_cur_hi;
  logic signed [DW-1:0] w_prev_lo;
  logic signed [DW-1:0] w_prev_hi;
  logic signed [DW-1:0] w_v_lo;
  logic signed [DW-1:0] w_v_hi;
  logic signed [DW-1:0] w_p;

  assign w_cur_lo  = cur_pair[DW-1:0];
  assign w_cur_hi  = cur_pair[2*DW-1:DW];
  assign w_prev_lo = prev_pair[DW-1:0];
  assign w_prev_hi = prev_pair[2*DW-1:DW];

  // Vertical max per column, horizontal max across the pair, then clamp
  always_comb begin
    w_v_lo = (w_cur_lo > w_prev_lo) ? w_cur_lo : w_prev_lo;
    w_v_hi = (w_cur_hi > w_prev_hi) ? w_cur_hi : w_prev_hi;
    w_p    = (w_v_hi > w_v_lo) ? w_v_hi : w_v_lo;
    pooled = (relu_en && w_p[DW-1]) ? '0 : w_p;
  end

endmodule : maxpool_pair_lane
`default_nettype wire

// File: rtl/relu_maxpool_stage.sv
`default_nettype none
// ============================================================================
// Module      : relu_maxpool_stage
// Description : Consumes PE output beats, applies optional ReLU and 2x2
//               stride-2 max-pooling over row pairs, and packs two pooled
//               half-vectors into one full-width output. Bypass mode passes
//               beats straight through (with optional ReLU). No backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_maxpool_stage
  import relu_maxpool_stage_pkg::*;
#(
  parameter int LENGTH    = c_length_default,
  parameter int DW        = c_int8_width,
  parameter int ROW_BEATS = c_pool_row_beats
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 relu_en,
  input  logic                 pool_en,
  input  logic                 in_en,
  input  logic [LENGTH*DW-1:0] in_vector,
  output logic                 out_en,
  output logic [LENGTH*DW-1:0] out_vector,
  output logic                 row_done,
  output logic                 busy
);

  localparam int c_half  = LENGTH / 2;
  localparam int c_cnt_w = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(ROW_BEATS - 1);

  state_t                  r_state;
  logic [c_cnt_w-1:0]      r_beat_cnt;
  logic                    r_half;
  logic [c_half*DW-1:0]    r_staged;
  logic                    r_out_en;
  logic [LENGTH*DW-1:0]    r_out_vector;
  logic                    r_row_done;
  logic [LENGTH*DW-1:0]    r_line_buf [ROW_BEATS];

  state_t                  w_eff_state;
  logic                    w_last;
  logic [c_cnt_w-1:0]      w_next_cnt;
  logic [LENGTH*DW-1:0]    w_prev;
  logic [c_half*DW-1:0]    w_pooled;
  logic [LENGTH*DW-1:0]    w_byp;

  // The beat arriving in IDLE is already beat 0 of a FILL or BYP row
  always_comb begin
    w_eff_state = r_state;
    if (r_state == ST_IDLE) begin
      w_eff_state = pool_en ? ST_FILL : ST_BYP;
    end
  end

  assign w_last     = (r_beat_cnt == c_last_beat);
  assign w_next_cnt = w_last ? '0 : r_beat_cnt + 1'b1;
  assign w_prev     = r_line_buf[r_beat_cnt];

  // One pooling lane per output element of the half-vector
  generate
    for (genvar k = 0; k < c_half; k++) begin : g_lane
      maxpool_pair_lane #(
        .DW (DW)
      ) u_lane (
        .cur_pair  (in_vector[2*k*DW +: 2*DW]),
        .prev_pair (w_prev[2*k*DW +: 2*DW]),
        .relu_en   (relu_en),
        .pooled    (w_pooled[k*DW +: DW])
      );
    end
  endgenerate

  // Bypass path: per-element clamp of negative values when ReLU is enabled
  generate
    for (genvar i = 0; i < LENGTH; i++) begin : g_byp
      assign w_byp[i*DW +: DW] = (relu_en && in_vector[i*DW + DW - 1]) ? '0
                                                                      : in_vector[i*DW +: DW];
    end
  endgenerate

  // Even-row storage; raw values so ReLU is applied only after the max
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < ROW_BEATS; b++) begin
        r_line_buf[b] <= '0;
      end
    end else if (!clear && in_en && (w_eff_state == ST_FILL)) begin
      r_line_buf[r_beat_cnt] <= in_vector;
    end
  end

  // Row state machine, beat counter, half-vector packing and output regs
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= '0;
      r_half       <= 1'b0;
      r_staged     <= '0;
      r_out_en     <= 1'b0;
      r_out_vector <= '0;
      r_row_done   <= 1'b0;
    end else begin
      r_out_en   <= 1'b0;
      r_row_done <= 1'b0;
      if (in_en) begin
        r_beat_cnt <= w_next_cnt;
        case (w_eff_state)
          ST_FILL: begin
            r_state <= w_last ? ST_POOL : ST_FILL;
          end
          ST_POOL: begin
            r_state <= w_last ? ST_FILL : ST_POOL;
            if (!r_half) begin
              r_staged <= w_pooled;
              r_half   <= 1'b1;
            end else begin
              r_out_vector <= {w_pooled, r_staged};
              r_out_en     <= 1'b1;
              r_row_done   <= w_last;
              r_half       <= 1'b0;
            end
          end
          ST_BYP: begin
            r_state      <= ST_BYP;
            r_out_vector <= w_byp;
            r_out_en     <= 1'b1;
            r_row_done   <= w_last;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign out_en     = r_out_en;
  assign out_vector = r_out_vector;
  assign row_done   = r_row_done;
  assign busy       = (r_state != ST_IDLE);

endmodule : relu_maxpool_stage
`default_nettype wire

// File: tb/tb_relu_maxpool_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu_maxpool_stage
// Description : Directed table-driven bench for relu_maxpool_stage with
//               hand sequences for in_en gaps, mid-row clear and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool_stage;

  localparam int LENGTH = 16;
  localparam int DW     = 8;
  localparam int VW     = LENGTH * DW;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          relu_en;
  logic          pool_en;
  logic          in_en;
  logic [VW-1:0] in_vector;
  logic          out_en;
  logic [VW-1:0] out_vector;
  logic          row_done;
  logic          busy;

  int total_checks;
  int passed_checks;

  typedef struct {
    string         name;
    logic          rst;
    logic          clr;
    logic          en;
    logic          relu;
    logic          pool;
    logic [VW-1:0] vec;
    logic          e_en;
    logic          e_row;
    logic          e_busy;
    logic          chk_vec;
    logic [VW-1:0] e_vec;
  } rec_t;

  rec_t tbl[$];

  relu_maxpool_stage #(
    .LENGTH    (LENGTH),
    .DW        (DW),
    .ROW_BEATS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .relu_en    (relu_en),
    .pool_en    (pool_en),
    .in_en      (in_en),
    .in_vector  (in_vector),
    .out_en     (out_en),
    .out_vector (out_vector),
    .row_done   (row_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] splat(input logic [7:0] b);
    logic [VW-1:0] v;
    for (int i = 0; i < LENGTH; i++) v[i*DW +: DW] = b;
    return v;
  endfunction

  // element i = i - 8
  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] v;
    for (int i = 0; i < LENGTH; i++) v[i*DW +: DW] = 8'(i - 8);
    return v;
  endfunction

  // ramp with negatives clamped: elements 0..8 -> 0, 9..15 -> 1..7
  function automatic logic [VW-1:0] ramp_relu();
    logic [VW-1:0] v;
    for (int i = 0; i < LENGTH; i++) v[i*DW +: DW] = (i <= 8) ? 8'd0 : 8'(i - 8);
    return v;
  endfunction

  // odd-row pattern: even elements 9, odd elements -3
  function automatic logic [VW-1:0] odd_pat();
    logic [VW-1:0] v;
    for (int i = 0; i < LENGTH; i++) v[i*DW +: DW] = (i % 2 != 0) ? 8'hFD : 8'd9;
    return v;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input string name, input logic rst, input logic clr, input logic en,
                     input logic relu, input logic pool, input logic [VW-1:0] vec,
                     input logic e_en, input logic e_row, input logic e_busy,
                     input logic chk_vec, input logic [VW-1:0] e_vec);
    rec_t r;
    r.name = name; r.rst = rst; r.clr = clr; r.en = en; r.relu = relu; r.pool = pool;
    r.vec = vec; r.e_en = e_en; r.e_row = e_row; r.e_busy = e_busy;
    r.chk_vec = chk_vec; r.e_vec = e_vec;
    tbl.push_back(r);
  endtask

  // Drive one cycle of inputs at the falling edge, check 1ns after the rising edge
  task automatic apply(input rec_t r);
    @(negedge clk);
    reset = r.rst; clear = r.clr; in_en = r.en; relu_en = r.relu;
    pool_en = r.pool; in_vector = r.vec;
    @(posedge clk);
    #1;
    chk({r.name, " out_en"},   VW'(out_en),   VW'(r.e_en));
    chk({r.name, " row_done"}, VW'(row_done), VW'(r.e_row));
    chk({r.name, " busy"},     VW'(busy),     VW'(r.e_busy));
    if (r.chk_vec) chk({r.name, " out_vector"}, out_vector, r.e_vec);
  endtask

  task automatic one(input string name, input logic rst, input logic clr, input logic en,
                     input logic relu, input logic pool, input logic [VW-1:0] vec,
                     input logic e_en, input logic e_row, input logic e_busy,
                     input logic chk_vec, input logic [VW-1:0] e_vec);
    rec_t r;
    r.name = name; r.rst = rst; r.clr = clr; r.en = en; r.relu = relu; r.pool = pool;
    r.vec = vec; r.e_en = e_en; r.e_row = e_row; r.e_busy = e_busy;
    r.chk_vec = chk_vec; r.e_vec = e_vec;
    apply(r);
  endtask

  initial begin
    logic [VW-1:0] z;
    logic [VW-1:0] s5;
    logic [VW-1:0] s9;
    logic [VW-1:0] sm20;
    int            n_out;

    total_checks = 0; passed_checks = 0;
    reset = 1'b1; clear = 1'b0; relu_en = 1'b0; pool_en = 1'b0;
    in_en = 1'b0; in_vector = '0;
    z = '0; s5 = splat(8'd5); s9 = splat(8'd9); sm20 = splat(8'hEC);

    // ---------------- table construction ----------------
    add("reset0", 1, 0, 0, 0, 0, z, 0, 0, 0, 1, z);
    add("reset1", 1, 0, 1, 1, 1, ramp(), 0, 0, 0, 1, z);
    // bypass with ReLU, one row of 4 beats
    for (int k = 0; k < 4; k++)
      add("byp_relu", 0, 0, 1, 1, 0, ramp(), 1, (k == 3), 1, 1, ramp_relu());
    add("byp_raw", 0, 0, 1, 0, 0, ramp(), 1, 0, 1, 1, ramp());
    add("byp_clear", 0, 1, 1, 0, 0, ramp(), 0, 0, 0, 1, z);
    add("idle_hold", 0, 0, 0, 0, 1, ramp(), 0, 0, 0, 1, z);
    // pooled rows, ReLU off
    for (int k = 0; k < 4; k++)
      add("pool_even", 0, 0, 1, 0, 1, s5, 0, 0, 1, 1, z);
    for (int k = 0; k < 4; k++)
      add("pool_odd", 0, 0, 1, 0, 1, odd_pat(), (k % 2 == 1), (k == 3), 1, (k != 0), s9);
    // all -20, ReLU on -> zeros
    for (int k = 0; k < 4; k++)
      add("neg_even_r", 0, 0, 1, 1, 1, sm20, 0, 0, 1, 1, s9);
    for (int k = 0; k < 4; k++)
      add("neg_odd_r", 0, 0, 1, 1, 1, sm20, (k % 2 == 1), (k == 3), 1, (k != 0), z);
    // all -20, ReLU off -> 0xEC everywhere
    for (int k = 0; k < 4; k++)
      add("neg_even", 0, 0, 1, 0, 1, sm20, 0, 0, 1, 1, z);
    for (int k = 0; k < 4; k++)
      add("neg_odd", 0, 0, 1, 0, 1, sm20, (k % 2 == 1), (k == 3), 1, (k != 0), sm20);
    add("pool_clear", 0, 1, 0, 0, 1, z, 0, 0, 0, 1, z);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // ---------------- in_en gaps: one beat every 3 cycles over 4 rows ----------------
    n_out = 0;
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) begin
        one("gap_beat", 0, 0, 1, 0, 1, (r % 2 == 1) ? odd_pat() : s5,
            (r % 2 == 1) && (b % 2 == 1), (r % 2 == 1) && (b == 3), 1,
            (r % 2 == 1) && (b % 2 == 1), s9);
        if (out_en) n_out++;
        for (int g = 0; g < 2; g++) begin
          one("gap_idle", 0, 0, 0, 0, 1, z, 0, 0, 1, 0, z);
          if (out_en) n_out++;
        end
      end
    end
    chk("gap_output_count", VW'(n_out), VW'(4));

    // ---------------- clear with a pending half ----------------
    for (int k = 0; k < 4; k++) one("clr_even", 0, 0, 1, 0, 1, s5, 0, 0, 1, 0, z);
    one("clr_odd0", 0, 0, 1, 0, 1, odd_pat(), 0, 0, 1, 0, z);
    one("clr_pulse", 0, 1, 0, 0, 1, z, 0, 0, 0, 1, z);
    one("clr_idle", 0, 0, 0, 0, 1, z, 0, 0, 0, 1, z);
    for (int k = 0; k < 4; k++) one("clr_refill", 0, 0, 1, 0, 1, splat(8'd7), 0, 0, 1, 1, z);
    for (int k = 0; k < 4; k++)
      one("clr_repool", 0, 0, 1, 0, 1, splat(8'd1), (k % 2 == 1), (k == 3), 1,
          (k != 0), splat(8'd7));

    // ---------------- reset during POOL with a same-cycle beat ----------------
    for (int k = 0; k < 4; k++) one("rst_even", 0, 0, 1, 0, 1, s5, 0, 0, 1, 1, splat(8'd7));
    one("rst_in_pool", 1, 0, 1, 0, 1, odd_pat(), 0, 0, 0, 1, z);
    one("rst_after", 0, 0, 1, 0, 1, splat(8'd3), 0, 0, 1, 1, z);
    for (int k = 0; k < 3; k++) one("rst_fill", 0, 0, 1, 0, 1, splat(8'd3), 0, 0, 1, 1, z);
    one("rst_pool0", 0, 0, 1, 0, 1, splat(8'd2), 0, 0, 1, 1, z);
    one("rst_pool1", 0, 0, 1, 0, 1, splat(8'd2), 1, 0, 1, 1, splat(8'd3));

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule : tb_relu_maxpool_stage
`default_nettype wire
